sprite_blitter: RTL and testbench

- Parametrised rectangular sprite blitter that generalises the fixed 21x21 draw/erase blocks into one engine.
- Writes pixel stream (x, y, colour, plot) to the VGA adapter, one pixel per clock, no rate divider.
- Supports draw, erase and move (erase old position then draw new position) under a start/busy/done handshake, with screen-edge clipping.
- Sits between the game control FSM and the VGA adapter.

---
 rtl/blit_pkg.sv | 24 ++
 rtl/scan_counter_2d.sv | 56 +++++
 rtl/sprite_blitter.sv | 161 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared definitions for the sprite blitter: operation modes, FSM encoding
// and default screen geometry.
package blit_pkg;

  localparam logic [1:0] MODE_DRAW  = 2'b00;
  localparam logic [1:0] MODE_ERASE = 2'b01;
  localparam logic [1:0] MODE_MOVE  = 2'b10;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ERASE  = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Counter width that stays legal for a dimension of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_counter_2d.sv
// Raster scan counter for one sprite pass: cx runs fastest, both wrap to 0
// after (SPR_W-1, SPR_H-1).
module scan_counter_2d
  import blit_pkg::*;
#(
  parameter int SPR_W = 21,
  parameter int SPR_H = 21,
  parameter int CX_W  = cnt_width(SPR_W),
  parameter int CY_W  = cnt_width(SPR_H)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last
);

  localparam logic [CX_W-1:0] CX_MAX = CX_W'(SPR_W - 1);
  localparam logic [CY_W-1:0] CY_MAX = CY_W'(SPR_H - 1);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en) begin
      if (cx_q == CX_MAX) begin
        cx_d = '0;
        cy_d = (cy_q == CY_MAX) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == CX_MAX) && (cy_q == CY_MAX);

endmodule

// File: rtl/sprite_blitter.sv
// Rectangular sprite draw/erase/move engine streaming one clipped pixel per
// clock to the VGA adapter, with a start/busy/done handshake.
module sprite_blitter
  import blit_pkg::*;
#(
  parameter int               X_W       = 8,
  parameter int               Y_W       = 7,
  parameter int               COL_W     = 3,
  parameter int               SPR_W     = 21,
  parameter int               SPR_H     = 21,
  parameter int               SCREEN_W  = DEF_SCREEN_W,
  parameter int               SCREEN_H  = DEF_SCREEN_H,
  parameter logic [COL_W-1:0] BG_COLOUR = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [X_W+Y_W-1:0]   new_coord,
  input  logic [X_W+Y_W-1:0]   old_coord,
  input  logic [COL_W-1:0]     fg_colour,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic [COL_W-1:0]     colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 done
);

  localparam int CX_W = cnt_width(SPR_W);
  localparam int CY_W = cnt_width(SPR_H);
  localparam logic [X_W:0] SCR_W_L = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H_L = (Y_W + 1)'(SCREEN_H);

  state_e state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [X_W+Y_W-1:0] new_q, new_d, old_q, old_d;
  logic [COL_W-1:0]   fg_q, fg_d, colour_q, colour_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               plot_q, plot_d, busy_q, busy_d, done_q, done_d;

  logic [CX_W-1:0]    cx;
  logic [CY_W-1:0]    cy;
  logic               last;
  logic               accept, in_pass, in_range;
  logic [X_W+Y_W-1:0] base;
  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;

  assign accept  = (state_q == ST_IDLE) && start;
  assign in_pass = (state_q == ST_ERASE) || (state_q == ST_DRAW);

  scan_counter_2d #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .CX_W  (CX_W),
    .CY_W  (CY_W)
  ) u_scan (
    .clock (clock),
    .reset (reset),
    .clear (state_q == ST_IDLE),
    .en    (in_pass),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );

  // Only the erase half of a move uses the old position.
  assign base  = (state_q == ST_ERASE && mode_q == MODE_MOVE) ? old_q : new_q;
  assign sum_x = {1'b0, base[X_W+Y_W-1:Y_W]} + (X_W + 1)'(cx);
  assign sum_y = {1'b0, base[Y_W-1:0]} + (Y_W + 1)'(cy);
  assign in_range = !sum_x[X_W] && !sum_y[Y_W] &&
                    (sum_x < SCR_W_L) && (sum_y < SCR_H_L);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_DRAW;
      new_q    <= '0;
      old_q    <= '0;
      fg_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      new_q    <= new_d;
      old_q    <= old_d;
      fg_q     <= fg_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (start)
          state_d = (mode == MODE_ERASE || mode == MODE_MOVE) ? ST_ERASE : ST_DRAW;
      ST_ERASE:
        if (last) state_d = (mode_q == MODE_MOVE) ? ST_DRAW : ST_FINISH;
      ST_DRAW:
        if (last) state_d = ST_FINISH;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    new_d    = new_q;
    old_d    = old_q;
    fg_d     = fg_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = accept;
        if (accept) begin
          mode_d = mode;
          new_d  = new_coord;
          old_d  = old_coord;
          fg_d   = fg_colour;
        end
      end
      ST_ERASE, ST_DRAW: begin
        busy_d = 1'b1;
        x_d    = sum_x[X_W-1:0];
        y_d    = sum_y[Y_W-1:0];
        plot_d = in_range;
        if (in_range) colour_d = (state_q == ST_ERASE) ? BG_COLOUR : fg_q;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    endcase
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised and directed bench: a 3x2 blitter and a default 21x21 blitter
// compared cycle by cycle against a pixel-list reference model.
module tb_sprite_blitter;

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  typedef struct {
    int x;
    int y;
    int c;
    bit p;
  } pix_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_s, start_d;
  logic [1:0]  mode;
  logic [14:0] new_coord, old_coord;
  logic [2:0]  fg_colour;
  logic        sel;

  logic [7:0] x_s, x_d;
  logic [6:0] y_s, y_d;
  logic [2:0] colour_s, colour_d;
  logic       plot_s, plot_d, busy_s, busy_d, done_s, done_d;

  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_colour;
  logic       o_plot, o_busy, o_done;

  int   errors = 0;
  int   checks = 0;
  pix_t exp_q[$];

  always #5 clock = ~clock;

  sprite_blitter #(.SPR_W(3), .SPR_H(2)) u_small (
    .clock(clock), .reset(reset), .start(start_s), .mode(mode),
    .new_coord(new_coord), .old_coord(old_coord), .fg_colour(fg_colour),
    .x(x_s), .y(y_s), .colour(colour_s), .plot(plot_s), .busy(busy_s), .done(done_s)
  );

  sprite_blitter u_def (
    .clock(clock), .reset(reset), .start(start_d), .mode(mode),
    .new_coord(new_coord), .old_coord(old_coord), .fg_colour(fg_colour),
    .x(x_d), .y(y_d), .colour(colour_d), .plot(plot_d), .busy(busy_d), .done(done_d)
  );

  assign o_x      = sel ? x_d : x_s;
  assign o_y      = sel ? y_d : y_s;
  assign o_colour = sel ? colour_d : colour_s;
  assign o_plot   = sel ? plot_d : plot_s;
  assign o_busy   = sel ? busy_d : busy_s;
  assign o_done   = sel ? done_d : done_s;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs != exp_v) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Expected pixel stream of one pass, straight from the screen geometry.
  task automatic add_pass(input int bx, input int by, input int col, input int sw, input int sh);
    for (int cy = 0; cy < sh; cy++) begin
      for (int cx = 0; cx < sw; cx++) begin
        pix_t p;
        p.x = (bx + cx) % 256;
        p.y = (by + cy) % 128;
        p.c = col;
        p.p = ((bx + cx) < SCR_W) && ((by + cy) < SCR_H);
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic set_start(input bit use_def, input logic v);
    if (use_def) start_d = v;
    else         start_s = v;
  endtask

  task automatic run_op(input bit use_def, input int m, input int nx, input int ny,
                        input int ox, input int oy, input int fg, input bit inject);
    int sw, sh, nplot;
    sw = use_def ? 21 : 3;
    sh = use_def ? 21 : 2;
    exp_q.delete();
    if (m == 1) add_pass(nx, ny, 0, sw, sh);
    else if (m == 2) begin
      add_pass(ox, oy, 0, sw, sh);
      add_pass(nx, ny, fg, sw, sh);
    end else add_pass(nx, ny, fg, sw, sh);

    sel       = use_def;
    mode      = 2'(m);
    new_coord = {8'(nx), 7'(ny)};
    old_coord = {8'(ox), 7'(oy)};
    fg_colour = 3'(fg);
    set_start(use_def, 1'b1);
    @(posedge clock); #1;
    set_start(use_def, 1'b0);
    mode      = 2'($urandom);
    new_coord = 15'($urandom);
    old_coord = 15'($urandom);
    fg_colour = 3'($urandom);
    check("busy_acc", int'(o_busy), 1);
    check("done_acc", int'(o_done), 0);

    nplot = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clock); #1;
      check("x", int'(o_x), exp_q[k].x);
      check("y", int'(o_y), exp_q[k].y);
      check("plot", int'(o_plot), int'(exp_q[k].p));
      if (exp_q[k].p) begin
        check("colour", int'(o_colour), exp_q[k].c);
        nplot++;
      end
      check("busy", int'(o_busy), 1);
      check("done", int'(o_done), 0);
      if (inject && k == 1) begin
        mode = 2'b01;
        set_start(use_def, 1'b1);
      end
      if (inject && k == 2) set_start(use_def, 1'b0);
    end

    @(posedge clock); #1;
    check("plot_fin", int'(o_plot), 0);
    check("done_fin", int'(o_done), 1);
    check("busy_fin", int'(o_busy), 0);
    $display("op inst=%0d mode=%0d new=(%0d,%0d) old=(%0d,%0d) fg=%0d cycles=%0d plotted=%0d errors=%0d",
             use_def, m, nx, ny, ox, oy, fg, exp_q.size(), nplot, errors);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      check("idle_plot", int'(o_plot), 0);
      check("idle_done", int'(o_done), 0);
      check("idle_busy", int'(o_busy), 0);
    end
  endtask

  initial begin
    reset = 1'b1; start_s = 1'b0; start_d = 1'b0; sel = 1'b0;
    mode = '0; new_coord = '0; old_coord = '0; fg_colour = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_x_s", int'(x_s), 0);       check("rst_y_s", int'(y_s), 0);
    check("rst_col_s", int'(colour_s), 0); check("rst_plot_s", int'(plot_s), 0);
    check("rst_busy_s", int'(busy_s), 0); check("rst_done_s", int'(done_s), 0);
    check("rst_x_d", int'(x_d), 0);       check("rst_busy_d", int'(busy_d), 0);
    check("rst_plot_d", int'(plot_d), 0); check("rst_done_d", int'(done_d), 0);
    reset = 1'b0;

    // Directed 3x2 cases, issued back to back so each start lands on the done cycle.
    run_op(0, 0, 10, 20, 0, 0, 4, 0);
    run_op(0, 2, 11, 20, 10, 20, 2, 0);
    run_op(0, 0, 158, 119, 0, 0, 5, 0);
    run_op(0, 1, 50, 60, 0, 0, 7, 0);
    run_op(0, 3, 159, 10, 0, 0, 6, 0);
    run_op(0, 2, 254, 126, 157, 118, 3, 0);
    run_op(0, 0, 30, 40, 0, 0, 6, 1);
    idle_check(3);
    run_op(0, 0, 31, 41, 0, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      int m, nx, ny, ox, oy;
      m  = $urandom_range(0, 3);
      nx = ($urandom_range(0, 1) == 1) ? $urandom_range(150, 255) : $urandom_range(0, 149);
      ny = ($urandom_range(0, 1) == 1) ? $urandom_range(110, 127) : $urandom_range(0, 109);
      ox = $urandom_range(0, 255);
      oy = $urandom_range(0, 127);
      run_op(0, m, nx, ny, ox, oy, $urandom_range(0, 7), 0);
      if ($urandom_range(0, 3) == 0) idle_check(1);
    end

    // Reset in the middle of a default-size draw.
    sel = 1'b1;
    mode = 2'b00; new_coord = '0; fg_colour = 3'd7;
    start_d = 1'b1;
    @(posedge clock); #1;
    start_d = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      check("pre_rst_x", int'(o_x), k);
      check("pre_rst_plot", int'(o_plot), 1);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort_plot", int'(o_plot), 0);
    check("abort_busy", int'(o_busy), 0);
    check("abort_done", int'(o_done), 0);
    check("abort_x", int'(o_x), 0);
    check("abort_y", int'(o_y), 0);
    reset = 1'b0;
    idle_check(2);

    run_op(1, 0, 0, 0, 0, 0, 3, 0);
    run_op(1, 2, 150, 110, 5, 5, 1, 0);
    idle_check(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
